// File: rtl/led_blink_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_driver
// Purpose  : Turns single-cycle event pulses into visible LED blinks (ON for
//            ON_TICKS slow ticks, then a forced OFF gap of OFF_TICKS ticks).
//            Extra requests queue in a saturating pending counter.
//            Define LED_BLINK_OVERFLOW_EN to add ovf_clr / ovf_sticky.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_driver #(
    parameter int unsigned TICK_DIV  = 19,
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_count
`ifdef LED_BLINK_OVERFLOW_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf_sticky
`endif
);

    localparam logic [1:0]        c_ST_IDLE   = 2'd0;
    localparam logic [1:0]        c_ST_ON     = 2'd1;
    localparam logic [1:0]        c_ST_GAP    = 2'd2;
    localparam logic [31:0]       c_TICK_LAST = TICK_DIV;
    localparam logic [31:0]       c_ON_LAST   = ON_TICKS - 1;
    localparam logic [31:0]       c_OFF_LAST  = OFF_TICKS - 1;
    localparam logic [PEND_W-1:0] c_MAX_PEND  = {PEND_W{1'b1}};

    if (ON_TICKS < 1) begin : g_chk_on_ticks
        $error("led_blink_driver: ON_TICKS must be >= 1");
    end
    if (OFF_TICKS < 1) begin : g_chk_off_ticks
        $error("led_blink_driver: OFF_TICKS must be >= 1");
    end
    if (PEND_W < 1) begin : g_chk_pend_w
        $error("led_blink_driver: PEND_W must be >= 1");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_tick_cnt;
    logic [31:0]       r_phase_cnt;
    logic              w_tick;
    logic              w_inc;
    logic              w_dec;
    logic              w_pend_any;
    logic              w_full;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_led;
    logic              r_busy;

    // The divider only runs while a blink is in progress, so every blink
    // starts on a fresh tick boundary.
    assign w_tick     = (r_state != c_ST_IDLE) && (r_tick_cnt == c_TICK_LAST);
    assign w_pend_any = (r_pend != '0);
    assign w_full     = (r_pend == c_MAX_PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // A pulse arriving in IDLE starts the blink itself.
                if (pulse_in) begin
                    w_state_nxt = c_ST_ON;
                end else if (w_pend_any) begin
                    w_state_nxt = c_ST_ON;
                    w_dec       = 1'b1;
                end
            end
            c_ST_ON: begin
                w_inc = pulse_in;
                if (w_tick && (r_phase_cnt == c_ON_LAST)) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                w_inc = pulse_in;
                if (w_tick && (r_phase_cnt == c_OFF_LAST)) begin
                    // A same-cycle pulse counts as pending here.
                    if (w_pend_any || pulse_in) begin
                        w_state_nxt = c_ST_ON;
                        w_dec       = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_inc && !w_dec) begin
            if (!w_full) begin
                w_pend_nxt = r_pend + PEND_W'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt  <= 32'd0;
            r_phase_cnt <= 32'd0;
            r_pend      <= '0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) || w_tick) begin
                r_tick_cnt <= 32'd0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
            end

            if (w_state_nxt != r_state) begin
                r_phase_cnt <= 32'd0;
            end else if (w_tick) begin
                r_phase_cnt <= r_phase_cnt + 32'd1;
            end

            r_pend <= w_pend_nxt;
            r_led  <= (w_state_nxt == c_ST_ON);
            r_busy <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign led_out       = r_led;
    assign busy          = r_busy;
    assign pending_count = r_pend;

`ifdef LED_BLINK_OVERFLOW_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = w_inc && !w_dec && w_full;

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf;
`else
    // Without the overflow flag, requests beyond saturation vanish silently.
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_blink_driver.sv
`default_nettype none
// Self-checking bench for led_blink_driver: per-cycle scoreboard against a
// cycle-count reference model, scenario table, and hand-written corner cases.
module tb_led_blink_driver;

    localparam int ON_LEN  = 4 * 20;
    localparam int GAP_LEN = 2 * 20;
    localparam int MAXP    = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       pulse_f = 1'b0;
    logic       led_out, busy;
    logic [2:0] pending_count;
    logic       led_f, busy_f;
    logic [2:0] pend_f;
`ifdef LED_BLINK_OVERFLOW_EN
    logic       ovf_sticky, ovf_f;
`endif

    always #5 clk = ~clk;

    led_blink_driver #(.TICK_DIV(19), .ON_TICKS(4), .OFF_TICKS(2), .PEND_W(3)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .led_out(led_out), .busy(busy), .pending_count(pending_count)
`ifdef LED_BLINK_OVERFLOW_EN
        , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
    );

    led_blink_driver #(.TICK_DIV(0), .ON_TICKS(1), .OFF_TICKS(1), .PEND_W(3)) dut_fast (
        .clk(clk), .rst(rst), .pulse_in(pulse_f),
        .led_out(led_f), .busy(busy_f), .pending_count(pend_f)
`ifdef LED_BLINK_OVERFLOW_EN
        , .ovf_clr(ovf_clr), .ovf_sticky(ovf_f)
`endif
    );

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [2:0] pend;
        logic       ovf;
    } exp_t;

    typedef struct {
        int n_pulses;
        int exp_blinks;
        int exp_peak;
        int exp_led_cyc;
        int exp_busy_cyc;
        bit exp_ovf;
    } scen_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // reference model: 0 idle, 1 on, 2 gap; m_left = cycles left in phase
    int m_state, m_left, m_pend;
    bit m_ovf;

    // per-scenario observations
    int   cyc, blinks, led_cyc, busy_cyc, last_busy, first_rise, peak;
    logic prev_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit p, input bit clr);
        bit set_ovf;
        set_ovf = 1'b0;
        case (m_state)
            0: begin
                if (p) begin
                    m_state = 1; m_left = ON_LEN;
                end else if (m_pend > 0) begin
                    m_pend--; m_state = 1; m_left = ON_LEN;
                end
            end
            1: begin
                if (p) begin
                    if (m_pend < MAXP) m_pend++; else set_ovf = 1'b1;
                end
                m_left--;
                if (m_left == 0) begin
                    m_state = 2; m_left = GAP_LEN;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend + int'(p) > 0) begin
                        m_pend = m_pend + int'(p) - 1; m_state = 1; m_left = ON_LEN;
                    end else begin
                        m_state = 0;
                    end
                end else if (p) begin
                    if (m_pend < MAXP) m_pend++; else set_ovf = 1'b1;
                end
            end
        endcase
        if (set_ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic clear_stats();
        cyc = 0; blinks = 0; led_cyc = 0; busy_cyc = 0;
        last_busy = -1; first_rise = -1; peak = 0; prev_led = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; pulse_in = 1'b0; ovf_clr = 1'b0; pulse_f = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_state = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        sb.delete();
        clear_stats();
    endtask

    task automatic cycle(input logic p, input logic clr);
        exp_t e;
        pulse_in = p; ovf_clr = clr;
        model_step(p, clr);
        e.led = (m_state == 1); e.busy = (m_state != 0);
        e.pend = 3'(m_pend); e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
`ifdef LED_BLINK_OVERFLOW_EN
        check("cycle_outputs", {led_out, busy, pending_count, ovf_sticky}, {e.led, e.busy, e.pend, e.ovf});
`else
        check("cycle_outputs", {led_out, busy, pending_count}, {e.led, e.busy, e.pend});
`endif
        if (led_out === 1'b1 && prev_led !== 1'b1) begin
            blinks++;
            if (first_rise < 0) first_rise = cyc;
        end
        prev_led = led_out;
        if (led_out === 1'b1) led_cyc++;
        if (busy === 1'b1) begin busy_cyc++; last_busy = cyc; end
        if (int'(pending_count) > peak) peak = int'(pending_count);
        cyc++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((busy !== 1'b0 || m_state != 0) && guard < 3000) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        check("drain_idle", {busy, led_out}, 2'b00);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[5];
        tbl[0] = '{1,  1, 0,  80, 120, 1'b0};
        tbl[1] = '{3,  3, 2, 240, 360, 1'b0};
        tbl[2] = '{8,  8, 7, 640, 960, 1'b0};
        tbl[3] = '{9,  8, 7, 640, 960, 1'b1};
        tbl[4] = '{10, 8, 7, 640, 960, 1'b1};

        apply_reset();
        check("reset_state", {led_out, busy, pending_count}, 5'b0);
        check("reset_state_fast", {led_f, busy_f, pend_f}, 5'b0);
`ifdef LED_BLINK_OVERFLOW_EN
        check("reset_ovf", ovf_sticky, 1'b0);
`endif

        for (int i = 0; i < 5; i++) begin
            apply_reset();
            for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
            for (int k = 0; k < tbl[i].n_pulses; k++) cycle(1'b1, 1'b0);
            drain();
            check("blink_count", blinks, tbl[i].exp_blinks);
            check("peak_pending", peak, tbl[i].exp_peak);
            check("led_on_cycles", led_cyc, tbl[i].exp_led_cyc);
            check("busy_cycles", busy_cyc, tbl[i].exp_busy_cyc);
            check("first_rise_cycle", first_rise, 10);
            check("last_busy_cycle", last_busy, 9 + tbl[i].exp_busy_cyc);
`ifdef LED_BLINK_OVERFLOW_EN
            check("ovf_flag", ovf_sticky, tbl[i].exp_ovf);
            if (tbl[i].exp_ovf) begin
                cycle(1'b0, 1'b1);
                check("ovf_cleared", ovf_sticky, 1'b0);
            end
`endif
        end

        // pulse on the final GAP cycle with one blink queued
        apply_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int k = 2; k < 120; k++) cycle(1'b0, 1'b0);
        check("gap_last_cycle", {led_out, busy, pending_count}, {1'b0, 1'b1, 3'd1});
        cycle(1'b1, 1'b0);
        check("gap_end_pulse", {led_out, busy, pending_count}, {1'b1, 1'b1, 3'd1});
        drain();
        check("gap_end_blinks", blinks, 3);

        // asynchronous reset in the middle of ON with three queued
        apply_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);
        check("pre_reset", {led_out, busy, pending_count}, {1'b1, 1'b1, 3'd3});
        #2 rst = 1'b1;
        #1;
        check("async_reset", {led_out, busy, pending_count}, 5'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_state = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        clear_stats();
        for (int k = 0; k < 300; k++) cycle(1'b0, 1'b0);
        check("no_blink_after_reset", blinks, 0);

        // fastest configuration: one tick per cycle
        apply_reset();
        pulse_f = 1'b1;
        @(posedge clk); #1;
        pulse_f = 1'b0;
        check("fast_on", {led_f, busy_f}, 2'b11);
        @(posedge clk); #1;
        check("fast_gap", {led_f, busy_f}, 2'b01);
        @(posedge clk); #1;
        check("fast_idle", {led_f, busy_f, pend_f}, 5'b0);
        @(posedge clk); #1;
        check("fast_stays_idle", {led_f, busy_f}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
- Output-side companion to the button input path. It turns single-cycle event pulses from the debounced-button logic into LED blinks a person can see.
- Each accepted pulse produces one blink: LED on for ON_TICKS slow ticks, then off for OFF_TICKS slow ticks.
- Pulses that arrive while a blink is running are queued in a saturating pending counter.
- Sits between the event logic and a board LED pin. The slow tick comes from an internal clock-enable divider on the 100 MHz board clock.

Parameters:
- TICK_DIV, 19, tick divider terminal count. One slow tick every TICK_DIV+1 clk cycles. Range 0..2^32-2.
- ON_TICKS, 4, LED-on duration in ticks. Must be >= 1.
- OFF_TICKS, 2, forced LED-off gap after each blink, in ticks. Must be >= 1.
- PEND_W, 3, width of the pending counter. Saturation value MAX_PEND = 2^PEND_W - 1.

Ports:
- clk  input  1  board clock, 100 MHz, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- pulse_in  input  1  single-cycle event request, sampled on every posedge
- led_out  output  1  LED drive, registered, 1 = lit
- busy  output  1  registered, 1 while state is ON or GAP
- pending_count  output  PEND_W  registered count of queued blinks not yet started

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, led_out = 0, busy = 0, pending_count = 0.
  - Tick counter = 0, phase counter = 0.
  - Reset asserted mid-blink aborts the blink and discards all queued requests.
- Tick divider:
  - 32-bit counter, held at 0 while in IDLE.
  - In ON/GAP it counts 0..TICK_DIV; tick = 1 for one cycle when the counter equals TICK_DIV, then the counter returns to 0.
  - TICK_DIV = 0 means tick is asserted every cycle.
- Phase counter: counts ticks within the current phase and clears on every phase change.
- State machine:
  - IDLE: if pulse_in = 1 or pending_count > 0, go to ON at the next edge.
    - If pulse_in started the blink, the pulse is consumed and pending_count is unchanged.
    - Otherwise pending_count decrements by 1.
  - ON: led_out = 1. Go to GAP on the edge where tick = 1 and phase = ON_TICKS-1.
  - GAP: led_out = 0. On the edge where tick = 1 and phase = OFF_TICKS-1:
    - if pending_count > 0 (evaluated after the same-cycle pulse_in update), go to ON and decrement pending_count;
    - otherwise go to IDLE.
- Timing:
  - led_out rises on the first posedge after the pulse_in cycle (latency 1 clk) when starting from IDLE.
  - ON lasts exactly ON_TICKS*(TICK_DIV+1) cycles; GAP lasts exactly OFF_TICKS*(TICK_DIV+1) cycles.
  - Back-to-back blinks follow each other with no extra IDLE cycle.
- Pending counter:
  - pulse_in in ON or GAP increments the count.
  - Increment and decrement in the same cycle leave the count unchanged.
  - An increment at MAX_PEND with no simultaneous decrement is dropped; the count stays at MAX_PEND.
  - pulse_in held high for k cycles counts as k requests.
- busy goes to 0 on the same edge the FSM enters IDLE.

Optional Feature:
- Macro LED_BLINK_OVERFLOW_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf_sticky (1 bit, registered, reset 0).
  - ovf_sticky sets on any dropped request (pulse_in while pending_count = MAX_PEND and no decrement that cycle).
  - ovf_sticky clears when ovf_clr = 1. If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists and dropped requests are silent. All other behaviour is identical.

Test Plan (defaults: TICK_DIV=19, ON_TICKS=4, OFF_TICKS=2, PEND_W=3):
- Single pulse_in at cycle 10 in IDLE:
  - led_out = 1 for cycles 11..90 (80 cycles), then 0 for 91..130;
  - busy = 1 for cycles 11..130; back in IDLE from cycle 131.
- Three pulses on consecutive cycles 10, 11, 12:
  - pending_count goes 0, 1, 2;
  - three 80-cycle blinks separated by 40-cycle gaps, pending_count decrementing at each ON entry; busy stays 1 throughout.
- Ten pulses on consecutive cycles from IDLE:
  - first pulse starts a blink; pending_count saturates at 7;
  - exactly 8 blinks occur;
  - with LED_BLINK_OVERFLOW_EN, ovf_sticky = 1 after the ninth pulse, and it clears after an ovf_clr pulse.
- pulse_in on the exact cycle GAP ends with pending_count = 1: next blink starts and pending_count stays 1.
- rst asserted for one cycle mid-ON with pending_count = 3: led_out, busy and pending_count go to 0 immediately; no further blinks occur.
- TICK_DIV = 0, ON_TICKS = 1, OFF_TICKS = 1 with one pulse: led_out high exactly 1 cycle, low 1 cycle, then IDLE.
